hd_imem_loader: RTL

- Parametrised sequential DMA engine that copies a program image from the HardDisk word store into InstructionMemory.
- It replaces the single-word, combinational HDtoReg/HDMI transfer path.
- The ControlUnit pulses `start` with a track, sector, destination and length. The block then streams one word per cycle and reports busy/done/err.
- While `busy` is high, the CPU clock enable is held off.

---
 rtl/hd_imem_loader_if.sv | 36 +++
 rtl/hd_imem_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hd_imem_loader_if.sv
// rtl/hd_imem_loader_if.sv - ControlUnit / HardDisk / InstructionMemory signal bundle for the image loader
// Optional HD_LOADER_CHECKSUM_EN adds the checksum signal.
interface hd_imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int HD_AW  = 16,
    parameter int IM_AW  = 10,
    parameter int LEN_W  = 11
);
    logic              start;
    logic              abort;
    logic [HD_AW-1:0]  src_track;
    logic [HD_AW-1:0]  src_sector;
    logic [IM_AW-1:0]  dst_base;
    logic [LEN_W-1:0]  length;
    logic [HD_AW-1:0]  hd_raddr;
    logic [DATA_W-1:0] hd_q;
    logic              im_we;
    logic [IM_AW-1:0]  im_waddr;
    logic [DATA_W-1:0] im_wdata;
    logic              busy;
    logic              done;
    logic              err;
`ifdef HD_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    modport master (output start, abort, src_track, src_sector, dst_base, length, hd_q,
                    input  hd_raddr, im_we, im_waddr, im_wdata, busy, done, err, checksum);
    modport slave  (input  start, abort, src_track, src_sector, dst_base, length, hd_q,
                    output hd_raddr, im_we, im_waddr, im_wdata, busy, done, err, checksum);
`else
    modport master (output start, abort, src_track, src_sector, dst_base, length, hd_q,
                    input  hd_raddr, im_we, im_waddr, im_wdata, busy, done, err);
    modport slave  (input  start, abort, src_track, src_sector, dst_base, length, hd_q,
                    output hd_raddr, im_we, im_waddr, im_wdata, busy, done, err);
`endif
endinterface

// File: rtl/hd_imem_loader.sv
// rtl/hd_imem_loader.sv - streaming HardDisk to InstructionMemory image copy engine
// Optional HD_LOADER_CHECKSUM_EN adds a running sum of written words.
module hd_imem_loader #(
    parameter int DATA_W      = 32,
    parameter int HD_AW       = 16,
    parameter int IM_AW       = 10,
    parameter int TRACK_WORDS = 256,
    parameter int LEN_W       = 11,
    parameter int RD_LAT      = 1
) (
    input logic              clock,
    input logic              reset,
    hd_imem_loader_if.slave  ldr
);
    localparam int SUM_W = HD_AW + LEN_W + 1;
    localparam int DST_W = ((IM_AW > LEN_W) ? IM_AW : LEN_W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [HD_AW-1:0]  trk_q, sec_q, rd_addr_q;
    logic [IM_AW-1:0]  dst_q, wr_addr_q;
    logic [LEN_W-1:0]  len_q, rd_left_q;
    logic              err_q, abort_q;
    logic [RD_LAT-1:0] vld_q;
    logic [IM_AW-1:0]  pipe_addr_q [RD_LAT];

    logic              issue, busy, done, accept, range_bad, tail_empty;
    logic [SUM_W-1:0]  src_base, src_end;
    logic [DST_W-1:0]  dst_end;

    assign accept    = (state_q == S_IDLE) && ldr.start;
    assign src_base  = SUM_W'(trk_q) * SUM_W'(TRACK_WORDS) + SUM_W'(sec_q);
    assign src_end   = src_base + SUM_W'(len_q);
    assign dst_end   = DST_W'(dst_q) + DST_W'(len_q);
    assign range_bad = (src_end > (SUM_W'(1) << HD_AW)) || (dst_end > (DST_W'(1) << IM_AW));

    // Leaving DRAIN one cycle early lets the final write overlap the state change.
    generate
        if (RD_LAT == 1) begin : g_tail1
            assign tail_empty = 1'b1;
        end else begin : g_tailn
            assign tail_empty = ~|vld_q[RD_LAT-2:0];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ldr.start) state_d = S_CHECK;
            S_CHECK: begin
                if (ldr.abort || range_bad) state_d = S_IDLE;
                else if (len_q == '0)       state_d = S_FIN;
                else                        state_d = S_RUN;
            end
            S_RUN:   if (ldr.abort || rd_left_q == LEN_W'(1)) state_d = S_DRAIN;
            S_DRAIN: if (tail_empty) state_d = (abort_q || ldr.abort) ? S_IDLE : S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_CHECK, S_DRAIN: busy = 1'b1;
            S_RUN: begin
                busy  = 1'b1;
                issue = 1'b1;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trk_q     <= '0;
            sec_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rd_left_q <= '0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            if (accept) begin
                trk_q   <= ldr.src_track;
                sec_q   <= ldr.src_sector;
                dst_q   <= ldr.dst_base;
                len_q   <= ldr.length;
                abort_q <= 1'b0;
            end
            if (state_q == S_CHECK) begin
                rd_addr_q <= src_base[HD_AW-1:0];
                wr_addr_q <= dst_q;
                rd_left_q <= len_q;
                err_q     <= range_bad & ~ldr.abort;
            end
            if (issue) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                wr_addr_q <= wr_addr_q + 1'b1;
                rd_left_q <= rd_left_q - 1'b1;
            end
            if (busy && ldr.abort) abort_q <= 1'b1;
        end
    end

    // Write address travels alongside the read so data and address line up after RD_LAT cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) pipe_addr_q[k] <= '0;
        end else begin
            vld_q[0]       <= issue;
            pipe_addr_q[0] <= wr_addr_q;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k]       <= vld_q[k-1];
                pipe_addr_q[k] <= pipe_addr_q[k-1];
            end
        end
    end

    assign ldr.hd_raddr = issue ? rd_addr_q : '0;
    assign ldr.im_we    = vld_q[RD_LAT-1];
    assign ldr.im_waddr = vld_q[RD_LAT-1] ? pipe_addr_q[RD_LAT-1] : '0;
    assign ldr.im_wdata = vld_q[RD_LAT-1] ? ldr.hd_q : '0;
    assign ldr.busy     = busy;
    assign ldr.done     = done;
    assign ldr.err      = err_q;

`ifdef HD_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                sum_q <= '0;
        else if (accept)           sum_q <= '0;
        else if (vld_q[RD_LAT-1])  sum_q <= sum_q + ldr.hd_q;
    end

    assign ldr.checksum = sum_q;
`endif
endmodule
